// File: rtl/mem_burst_pkg.sv
// Shared command codes, FSM states and grant directions for the MIG burst engine.
package mem_burst_pkg;

   localparam logic [2:0] APP_CMD_WRITE = 3'b000;
   localparam logic [2:0] APP_CMD_READ  = 3'b001;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD      = 3'd1,
      RD_WAIT = 3'd2,
      WR      = 3'd3,
      DONE    = 3'd4
   } state_t;

   typedef enum logic {
      GNT_RD = 1'b0,
      GNT_WR = 1'b1
   } grant_t;

endpackage

// File: rtl/mem_burst_rr_arb.sv
// Two-way round-robin arbiter between read and write burst requests.
// Grant decision is combinational; the last-grant register only moves when a burst completes.
module mem_burst_rr_arb
   import mem_burst_pkg::*;
(
   input  logic   mem_clk,
   input  logic   rst,
   input  logic   calib_done,
   input  logic   rd_req,
   input  logic   wr_req,
   input  logic   upd_en,
   input  grant_t upd_gnt,
   output logic   gnt_vld,
   output grant_t gnt
);

   grant_t last_grant;

   always_ff @(posedge mem_clk or posedge rst) begin
      if (rst)
         last_grant <= GNT_WR;
      else if (upd_en)
         last_grant <= upd_gnt;
   end

   always_comb begin
      gnt_vld = calib_done & (rd_req | wr_req);
      gnt     = GNT_WR;
      if (rd_req && wr_req)
         gnt = (last_grant == GNT_WR) ? GNT_RD : GNT_WR;
      else if (rd_req)
         gnt = GNT_RD;
   end

endmodule

// File: rtl/mem_burst_arb.sv
// Burst engine for the MIG native app port: one user burst becomes len single-beat commands.
// Write data is handshaked on app_wdf_rdy independently of command acceptance on app_rdy.
module mem_burst_arb
   import mem_burst_pkg::*;
#(
   parameter int MEM_DATA_BITS    = 64,
   parameter int MEM_IF_ADDR_BITS = 27,
   parameter int ADDR_BITS        = 24,
   parameter int LEN_BITS         = 10,
   parameter int ADDR_LSB         = 3
)(
   input  logic                          mem_clk,
   input  logic                          rst,
   input  logic                          init_calib_complete,
   input  logic                          rd_burst_req,
   input  logic                          wr_burst_req,
   input  logic [LEN_BITS-1:0]           rd_burst_len,
   input  logic [LEN_BITS-1:0]           wr_burst_len,
   input  logic [ADDR_BITS-1:0]          rd_burst_addr,
   input  logic [ADDR_BITS-1:0]          wr_burst_addr,
   input  logic [MEM_DATA_BITS-1:0]      wr_burst_data,
   input  logic [MEM_DATA_BITS/8-1:0]    wr_burst_mask,
   output logic                          wr_burst_data_req,
   output logic [MEM_DATA_BITS-1:0]      rd_burst_data,
   output logic                          rd_burst_data_valid,
   output logic                          rd_burst_finish,
   output logic                          wr_burst_finish,
   output logic                          burst_finish,
   output logic                          busy,
   output logic [MEM_IF_ADDR_BITS-1:0]   app_addr,
   output logic [2:0]                    app_cmd,
   output logic                          app_en,
   output logic [MEM_DATA_BITS-1:0]      app_wdf_data,
   output logic [MEM_DATA_BITS/8-1:0]    app_wdf_mask,
   output logic                          app_wdf_wren,
   output logic                          app_wdf_end,
   input  logic [MEM_DATA_BITS-1:0]      app_rd_data,
   input  logic                          app_rd_data_valid,
   input  logic                          app_rdy,
   input  logic                          app_wdf_rdy
);

   localparam int SH_BITS = ADDR_BITS + ADDR_LSB;
   localparam logic [MEM_IF_ADDR_BITS-1:0] ADDR_STEP = MEM_IF_ADDR_BITS'(1) << ADDR_LSB;

   state_t               state;
   grant_t               gnt_q;
   grant_t               arb_gnt;
   logic                 arb_vld;
   logic [LEN_BITS-1:0]  len_q, cmd_cnt, data_cnt, cmd_nxt, data_nxt, sel_len;
   logic [ADDR_BITS-1:0] sel_addr;
   logic [SH_BITS-1:0]   sel_shift;
   logic                 cmd_acc, data_inc, in_rd;

   mem_burst_rr_arb u_arb (
      .mem_clk    (mem_clk),
      .rst        (rst),
      .calib_done (init_calib_complete),
      .rd_req     (rd_burst_req),
      .wr_req     (wr_burst_req),
      .upd_en     (state == DONE),
      .upd_gnt    (gnt_q),
      .gnt_vld    (arb_vld),
      .gnt        (arb_gnt)
   );

   assign in_rd               = (state == RD) || (state == RD_WAIT);
   assign app_en              = ((state == RD) || (state == WR)) && (cmd_cnt < len_q);
   assign cmd_acc             = app_en & app_rdy;
   assign wr_burst_data_req   = (state == WR) && (data_cnt < len_q) && app_wdf_rdy;
   assign app_wdf_wren        = wr_burst_data_req;
   assign app_wdf_end         = wr_burst_data_req;
   assign app_wdf_data        = wr_burst_data;
   assign app_wdf_mask        = wr_burst_mask;
   assign rd_burst_data       = app_rd_data;
   assign rd_burst_data_valid = in_rd & app_rd_data_valid;
   assign burst_finish        = rd_burst_finish | wr_burst_finish;
   assign busy                = (state != IDLE);

   // The completing cycle is judged on next-count values so DONE follows the last event directly.
   assign data_inc  = wr_burst_data_req | rd_burst_data_valid;
   assign cmd_nxt   = cmd_cnt + LEN_BITS'(cmd_acc);
   assign data_nxt  = data_cnt + LEN_BITS'(data_inc);
   assign sel_len   = (arb_gnt == GNT_RD) ? rd_burst_len : wr_burst_len;
   assign sel_addr  = (arb_gnt == GNT_RD) ? rd_burst_addr : wr_burst_addr;
   assign sel_shift = SH_BITS'(sel_addr) << ADDR_LSB;

   always_ff @(posedge mem_clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         gnt_q           <= GNT_WR;
         len_q           <= '0;
         cmd_cnt         <= '0;
         data_cnt        <= '0;
         app_addr        <= '0;
         app_cmd         <= APP_CMD_WRITE;
         rd_burst_finish <= 1'b0;
         wr_burst_finish <= 1'b0;
      end else begin
         cmd_cnt  <= cmd_nxt;
         data_cnt <= data_nxt;
         if (cmd_acc)
            app_addr <= app_addr + ADDR_STEP;
         case (state)
            IDLE: begin
               if (arb_vld) begin
                  gnt_q    <= arb_gnt;
                  len_q    <= sel_len;
                  cmd_cnt  <= '0;
                  data_cnt <= '0;
                  app_addr <= MEM_IF_ADDR_BITS'(sel_shift);
                  app_cmd  <= (arb_gnt == GNT_RD) ? APP_CMD_READ : APP_CMD_WRITE;
                  if (sel_len == '0) begin
                     state           <= DONE;
                     rd_burst_finish <= (arb_gnt == GNT_RD);
                     wr_burst_finish <= (arb_gnt == GNT_WR);
                  end else if (arb_gnt == GNT_RD) begin
                     state <= RD;
                  end else begin
                     state <= WR;
                  end
               end
            end
            RD: begin
               if (cmd_nxt == len_q) begin
                  if (data_nxt == len_q) begin
                     state           <= DONE;
                     rd_burst_finish <= 1'b1;
                  end else begin
                     state <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (data_nxt == len_q) begin
                  state           <= DONE;
                  rd_burst_finish <= 1'b1;
               end
            end
            WR: begin
               if ((cmd_nxt == len_q) && (data_nxt == len_q)) begin
                  state           <= DONE;
                  wr_burst_finish <= 1'b1;
               end
            end
            DONE: begin
               state           <= IDLE;
               rd_burst_finish <= 1'b0;
               wr_burst_finish <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_burst_arb.sv
// Randomised bench for mem_burst_arb with a transaction-level reference model.
module tb_mem_burst_arb;

   localparam int DW = 64;
   localparam int MW = 8;
   localparam int AW = 27;
   localparam int UAW = 24;
   localparam int LW = 10;
   localparam longint AMOD = 64'd1 << AW;

   logic           mem_clk = 1'b0;
   logic           rst, init_calib_complete, rd_burst_req, wr_burst_req;
   logic [LW-1:0]  rd_burst_len, wr_burst_len;
   logic [UAW-1:0] rd_burst_addr, wr_burst_addr;
   logic [DW-1:0]  wr_burst_data, rd_burst_data, app_wdf_data, app_rd_data;
   logic [MW-1:0]  wr_burst_mask, app_wdf_mask;
   logic           wr_burst_data_req, rd_burst_data_valid, rd_burst_finish, wr_burst_finish;
   logic           burst_finish, busy, app_en, app_wdf_wren, app_wdf_end;
   logic [AW-1:0]  app_addr;
   logic [2:0]     app_cmd;
   logic           app_rd_data_valid, app_rdy, app_wdf_rdy;

   mem_burst_arb dut (
      .mem_clk(mem_clk), .rst(rst), .init_calib_complete(init_calib_complete),
      .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
      .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
      .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
      .wr_burst_data(wr_burst_data), .wr_burst_mask(wr_burst_mask),
      .wr_burst_data_req(wr_burst_data_req), .rd_burst_data(rd_burst_data),
      .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_finish(rd_burst_finish),
      .wr_burst_finish(wr_burst_finish), .burst_finish(burst_finish), .busy(busy),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
      .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
      .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy)
   );

   always #5 mem_clk = ~mem_clk;

   typedef struct {
      int            due;
      logic [DW-1:0] d;
   } rsp_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   rsp_t             pipe[$];
   logic [AW+2:0]    cmd_log[$];
   logic [MW+DW-1:0] wbeat_log[$];
   logic [MW+DW-1:0] wr_src[$];
   logic [DW-1:0]    rd_log[$];
   int               fin_order[$];
   int wr_idx, lat, rdy_mode, stall_end, req_cyc;
   int first_en_cyc, first_wbeat_cyc, last_wbeat_cyc, last_wcmd_cyc, last_rd_cyc;
   int rd_fin_cyc, wr_fin_cyc;
   bit m_last_wr;

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return {32'(a) ^ 32'hC0DE_0000, ~32'(a)};
   endfunction

   // One clock of the environment: observe at negedge, drive #1 after posedge.
   task automatic step();
      bit take, rf, wf;
      rsp_t r;
      @(negedge mem_clk);
      take = 1'b0;
      rf = rd_burst_finish;
      wf = wr_burst_finish;
      if (app_en && first_en_cyc < 0) first_en_cyc = cyc;
      if (app_en && app_rdy) begin
         cmd_log.push_back({app_cmd, app_addr});
         if (app_cmd == 3'b001) begin
            r.due = cyc + lat;
            r.d = pat(app_addr);
            pipe.push_back(r);
         end else begin
            last_wcmd_cyc = cyc;
         end
      end
      if (app_wdf_wren) begin
         wbeat_log.push_back({app_wdf_mask, app_wdf_data});
         if (first_wbeat_cyc < 0) first_wbeat_cyc = cyc;
         last_wbeat_cyc = cyc;
         take = 1'b1;
         checks++;
         if ({wr_burst_data_req, app_wdf_end, app_wdf_mask, app_wdf_data} !==
             {2'b11, wr_burst_mask, wr_burst_data}) begin
            failures++;
            $display("FAIL wdf_passthru: got req/end=%b%b data=%h required 11 data=%h",
                     wr_burst_data_req, app_wdf_end, app_wdf_data, wr_burst_data);
         end
      end
      if (rd_burst_data_valid) begin
         rd_log.push_back(rd_burst_data);
         last_rd_cyc = cyc;
      end
      if (rf) begin rd_fin_cyc = cyc; fin_order.push_back(0); end
      if (wf) begin wr_fin_cyc = cyc; fin_order.push_back(1); end
      if (rf || wf) begin
         checks++;
         if (burst_finish !== 1'b1) begin
            failures++;
            $display("FAIL burst_finish_or: got %b required 1", burst_finish);
         end
      end
      @(posedge mem_clk);
      #1;
      cyc++;
      if (take) wr_idx++;
      if (rf) rd_burst_req = 1'b0;
      if (wf) wr_burst_req = 1'b0;
      {wr_burst_mask, wr_burst_data} = (wr_idx < wr_src.size()) ? wr_src[wr_idx] : '0;
      if (pipe.size() > 0 && pipe[0].due <= cyc) begin
         r = pipe.pop_front();
         app_rd_data_valid = 1'b1;
         app_rd_data = r.d;
      end else begin
         app_rd_data_valid = 1'b0;
         app_rd_data = {$urandom, $urandom};
      end
      case (rdy_mode)
         1: begin app_rdy = (cyc % 2 == 0); app_wdf_rdy = 1'b1; end
         2: begin app_rdy = ($urandom_range(0, 3) != 0); app_wdf_rdy = ($urandom_range(0, 2) != 0); end
         3: begin app_rdy = 1'b1; app_wdf_rdy = (cyc >= stall_end); end
         default: begin app_rdy = 1'b1; app_wdf_rdy = 1'b1; end
      endcase
   endtask

   task automatic clear_logs();
      cmd_log.delete(); wbeat_log.delete(); rd_log.delete(); fin_order.delete(); wr_src.delete();
      wr_idx = 0; first_en_cyc = -1; first_wbeat_cyc = -1; last_wbeat_cyc = -1;
      last_wcmd_cyc = -1; last_rd_cyc = -1; rd_fin_cyc = -1; wr_fin_cyc = -1;
   endtask

   // Issue one or two requests together and compare all traffic against the model.
   task automatic run_pair(input bit do_rd, input int rlen, input int raddr,
                           input bit do_wr, input int wlen, input int waddr, input string tag);
      int            gq[$];
      logic [AW+2:0] exp_cmd[$];
      logic [DW-1:0] exp_rd[$];
      int bad, t, n;
      bit done;
      if (do_rd && do_wr) begin
         gq.push_back(m_last_wr ? 0 : 1);
         gq.push_back(m_last_wr ? 1 : 0);
      end else begin
         gq.push_back(do_wr ? 1 : 0);
      end
      m_last_wr = (gq[gq.size()-1] == 1);
      foreach (gq[k]) begin
         n = (gq[k] == 1) ? wlen : rlen;
         for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            a = AW'((longint'((gq[k] == 1) ? waddr : raddr) * 8 + longint'(i) * 8) % AMOD);
            exp_cmd.push_back({(gq[k] == 1) ? 3'b000 : 3'b001, a});
            if (gq[k] == 0) exp_rd.push_back(pat(a));
         end
      end
      clear_logs();
      if (do_wr)
         for (int i = 0; i < wlen; i++) wr_src.push_back({8'($urandom), $urandom, $urandom});
      {wr_burst_mask, wr_burst_data} = (wr_src.size() > 0) ? wr_src[0] : '0;
      rd_burst_len = LW'(rlen); rd_burst_addr = UAW'(raddr);
      wr_burst_len = LW'(wlen); wr_burst_addr = UAW'(waddr);
      rd_burst_req = do_rd; wr_burst_req = do_wr;
      req_cyc = cyc;
      done = 1'b0;
      for (t = 0; t < 3000 && !done; t++) begin
         step();
         done = (fin_order.size() >= gq.size());
      end
      repeat (3) step();

      checks++;
      if (!done) begin
         failures++;
         $display("FAIL %s timeout: got %0d finish pulses required %0d", tag, fin_order.size(), gq.size());
         rd_burst_req = 1'b0; wr_burst_req = 1'b0; rst = 1'b1;
         step(); rst = 1'b0; m_last_wr = 1'b1; pipe.delete();
      end
      checks++;
      bad = (cmd_log.size() != exp_cmd.size()) ? 0 : -1;
      for (int i = 0; bad < 0 && i < exp_cmd.size(); i++) if (cmd_log[i] !== exp_cmd[i]) bad = i;
      if (bad >= 0) begin
         failures++;
         $display("FAIL %s cmd_seq: got %0d cmds required %0d, first difference at %0d (got %h required %h)",
                  tag, cmd_log.size(), exp_cmd.size(), bad,
                  (bad < cmd_log.size()) ? cmd_log[bad] : '0, (bad < exp_cmd.size()) ? exp_cmd[bad] : '0);
      end
      checks++;
      bad = (wbeat_log.size() != wr_src.size()) ? 0 : -1;
      for (int i = 0; bad < 0 && i < wr_src.size(); i++) if (wbeat_log[i] !== wr_src[i]) bad = i;
      if (bad >= 0) begin
         failures++;
         $display("FAIL %s wr_beats: got %0d beats required %0d, first difference at %0d",
                  tag, wbeat_log.size(), wr_src.size(), bad);
      end
      checks++;
      bad = (rd_log.size() != exp_rd.size()) ? 0 : -1;
      for (int i = 0; bad < 0 && i < exp_rd.size(); i++) if (rd_log[i] !== exp_rd[i]) bad = i;
      if (bad >= 0) begin
         failures++;
         $display("FAIL %s rd_data: got %0d beats required %0d, first difference at %0d",
                  tag, rd_log.size(), exp_rd.size(), bad);
      end
      checks++;
      if (fin_order != gq) begin
         failures++;
         $display("FAIL %s finish_order: got %p required %p", tag, fin_order, gq);
      end
      if (do_rd && rlen > 0) begin
         checks++;
         if (rd_fin_cyc != last_rd_cyc + 1) begin
            failures++;
            $display("FAIL %s rd_finish_time: got cycle %0d required %0d", tag, rd_fin_cyc, last_rd_cyc + 1);
         end
      end
      if (do_wr && wlen > 0) begin
         n = (last_wcmd_cyc > last_wbeat_cyc) ? last_wcmd_cyc : last_wbeat_cyc;
         checks++;
         if (wr_fin_cyc != n + 1) begin
            failures++;
            $display("FAIL %s wr_finish_time: got cycle %0d required %0d", tag, wr_fin_cyc, n + 1);
         end
      end
      if (((gq[0] == 1) ? wlen : rlen) > 0) begin
         checks++;
         if (first_en_cyc != req_cyc + 1) begin
            failures++;
            $display("FAIL %s first_app_en: got cycle %0d required %0d", tag, first_en_cyc, req_cyc + 1);
         end
      end
      checks++;
      if ({busy, app_en} !== 2'b00) begin
         failures++;
         $display("FAIL %s idle_after: got busy/app_en=%b%b required 00", tag, busy, app_en);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({busy, app_en, app_cmd, app_addr, wr_burst_data_req, app_wdf_wren, burst_finish} !== '0) begin
         failures++;
         $display("FAIL reset_values: got busy=%b en=%b cmd=%b addr=%h required all zero", busy, app_en, app_cmd, app_addr);
      end
      repeat (3) @(posedge mem_clk);
      #1 rst = 1'b0;
      step(); step();
      checks++;
      if ({busy, app_en, app_addr, rd_burst_finish, wr_burst_finish} !== '0) begin
         failures++;
         $display("FAIL idle_values: got busy=%b en=%b addr=%h required zeros", busy, app_en, app_addr);
      end
   endtask

   task automatic test_arb();
      rdy_mode = 0; lat = 3;
      rd_burst_len = 2; wr_burst_len = 2; rd_burst_req = 1'b1; wr_burst_req = 1'b1;
      clear_logs();
      repeat (4) step();
      checks++;
      if (busy !== 1'b0 || first_en_cyc >= 0) begin
         failures++;
         $display("FAIL arb_calib_gate: got busy=%b first_en=%0d required 0 and none", busy, first_en_cyc);
      end
      init_calib_complete = 1'b1;
      run_pair(1, 2, 'h100, 1, 2, 'h200, "arb_first");
      for (int i = 0; i < 3; i++) run_pair(1, 2, 'h300 + i, 1, 2, 'h400 + i, "arb_repeat");
   endtask

   task automatic test_write_basic();
      logic [AW-1:0] exp_a [4] = '{27'h80, 27'h88, 27'h90, 27'h98};
      rdy_mode = 0;
      run_pair(0, 0, 0, 1, 4, 'h10, "wr_basic");
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= cmd_log.size() || cmd_log[i][AW-1:0] !== exp_a[i]) begin
            failures++;
            $display("FAIL wr_basic_addr%0d: got %h required %h", i,
                     (i < cmd_log.size()) ? cmd_log[i][AW-1:0] : '0, exp_a[i]);
         end
      end
   endtask

   task automatic test_read_latency();
      rdy_mode = 1; lat = 10;
      run_pair(1, 3, 'h2345, 0, 0, 0, "rd_latency");
   endtask

   task automatic test_wdf_stall();
      rdy_mode = 3; stall_end = cyc + 7; app_wdf_rdy = 1'b0;
      run_pair(0, 0, 0, 1, 5, 'h40, "wdf_stall");
      checks++;
      if (!(last_wcmd_cyc < first_wbeat_cyc)) begin
         failures++;
         $display("FAIL wdf_stall_order: got last cmd %0d first beat %0d required cmds first", last_wcmd_cyc, first_wbeat_cyc);
      end
   endtask

   task automatic test_zero_len();
      rdy_mode = 0;
      run_pair(0, 0, 0, 1, 0, 'h55, "zero_len");
      checks++;
      if (!(wr_fin_cyc > req_cyc && wr_fin_cyc <= req_cyc + 2 && first_en_cyc < 0)) begin
         failures++;
         $display("FAIL zero_len_pulse: got finish cycle %0d (req %0d) first_en %0d required within 2 cycles and no app_en",
                  wr_fin_cyc, req_cyc, first_en_cyc);
      end
   endtask

   task automatic test_addr_wrap();
      rdy_mode = 0;
      run_pair(0, 0, 0, 1, 2, 'hFFFFFF, "addr_wrap");
   endtask

   task automatic test_reset_mid_read();
      rdy_mode = 0; lat = 4;
      clear_logs();
      rd_burst_len = 8; rd_burst_addr = 'h77; rd_burst_req = 1'b1;
      repeat (6) step();
      rst = 1'b1;
      rd_burst_req = 1'b0;
      #1;
      checks++;
      if ({busy, app_en, app_cmd, app_addr, rd_burst_data_valid, burst_finish} !== '0) begin
         failures++;
         $display("FAIL mid_read_reset: got busy=%b en=%b cmd=%b addr=%h rvld=%b required zeros",
                  busy, app_en, app_cmd, app_addr, rd_burst_data_valid);
      end
      m_last_wr = 1'b1;
      step();
      rst = 1'b0;
      rd_log.delete();
      repeat (15) step();
      checks++;
      if (rd_log.size() != 0 || pipe.size() != 0) begin
         failures++;
         $display("FAIL stale_rd_data: got %0d forwarded beats required 0", rd_log.size());
      end
      run_pair(1, 3, 'h1000, 0, 0, 0, "rd_after_reset");
   endtask

   task automatic test_random();
      for (int it = 0; it < 12; it++) begin
         bit dr, dw;
         int rl, wl;
         dr = 1'($urandom_range(0, 1));
         dw = 1'($urandom_range(0, 1));
         if (!dr && !dw) dr = 1'b1;
         rl = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12));
         wl = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12));
         lat = int'($urandom_range(1, 12));
         rdy_mode = int'($urandom_range(0, 2));
         run_pair(dr, rl, int'($urandom_range(0, 24'hFFFFFF)), dw, wl,
                  int'($urandom_range(0, 24'hFFFFFF)), "random");
      end
   endtask

   initial begin
      rst = 1'b1; init_calib_complete = 1'b0;
      rd_burst_req = 1'b0; wr_burst_req = 1'b0;
      rd_burst_len = '0; wr_burst_len = '0; rd_burst_addr = '0; wr_burst_addr = '0;
      wr_burst_data = '0; wr_burst_mask = '0;
      app_rd_data = '0; app_rd_data_valid = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      rdy_mode = 0; lat = 1; stall_end = 0; req_cyc = 0; m_last_wr = 1'b1;
      clear_logs();
      test_reset();
      test_arb();
      test_write_basic();
      test_read_latency();
      test_wdf_stall();
      test_zero_len();
      test_addr_wrap();
      test_reset_mid_read();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
